// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU constants and divider state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = DIV_IDLE,
        S_CALC = DIV_CALC,
        S_DONE = DIV_DONE
    } divState_t;

endpackage
`default_nettype wire

// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_if
//  Description : Start/done handshake and operand/result bus of the divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface div_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div0, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration on magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  wire logic [WIDTH-1:0] rem,
    input  wire logic [WIDTH-1:0] quo,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] remNext,
    output logic      [WIDTH-1:0] quoNext
);

    logic [WIDTH-1:0] w_remShift;
    logic [WIDTH:0]   w_trial;
    logic             w_negative;

    // rem is always below a divisor magnitude of at most 2^(WIDTH-1), so the
    // WIDTH+1-bit trial keeps a reliable sign bit.
    assign w_remShift = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign w_trial    = {rem, quo[WIDTH-1]} - {1'b0, divisor};
    assign w_negative = w_trial[WIDTH];

    assign remNext = w_negative ? w_remShift : w_trial[WIDTH-1:0];
    assign quoNext = {quo[WIDTH-2:0], ~w_negative};

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multicycle signed restoring divider (MIPS DIV) for HI/LO.
//                Optional macro DIV_FAST_ZERO_EN short-cuts a zero dividend.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  wire logic clk,
    input  wire logic reset,
    div_if.slave      bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_lastCount = CNT_W'(WIDTH - 1);

    divState_t        r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_signQ;
    logic             r_signR;
    logic             r_bypass;
    logic             r_zeroDiv;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_absDividend;
    logic [WIDTH-1:0] w_absDivisor;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;

    // The most-negative value negates to itself, which is its correct
    // unsigned magnitude.
    assign w_absDividend = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_absDivisor  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem     (r_rem),
        .quo     (r_quo),
        .divisor (r_div),
        .remNext (w_remNext),
        .quoNext (w_quoNext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_signQ   <= 1'b0;
            r_signR   <= 1'b0;
            r_bypass  <= 1'b0;
            r_zeroDiv <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_div0 <= 1'b0;
                    if (bus.start) begin
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                        // Short requests take a single bypass cycle in CALC so
                        // their completion lands one edge after acceptance.
                        if (bus.divisor == '0) begin
                            r_bypass  <= 1'b1;
                            r_zeroDiv <= 1'b1;
                            r_count   <= '0;
                        end
`ifdef DIV_FAST_ZERO_EN
                        else if (bus.dividend == '0) begin
                            r_bypass  <= 1'b1;
                            r_zeroDiv <= 1'b0;
                            r_count   <= '0;
                        end
`endif
                        else begin
                            r_bypass  <= 1'b0;
                            r_zeroDiv <= 1'b0;
                            r_rem     <= '0;
                            r_quo     <= w_absDividend;
                            r_div     <= w_absDivisor;
                            r_signQ   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            r_signR   <= bus.dividend[WIDTH-1];
                            r_count   <= c_lastCount;
                        end
                    end
                end

                S_CALC: begin
                    if (r_bypass) begin
                        r_done  <= 1'b1;
                        r_div0  <= r_zeroDiv;
                        r_state <= S_DONE;
                        if (!r_zeroDiv) begin
                            r_hi <= '0;
                            r_lo <= '0;
                        end
                    end else begin
                        r_rem <= w_remNext;
                        r_quo <= w_quoNext;
                        if (r_count == '0) begin
                            r_lo    <= r_signQ ? -w_quoNext : w_quoNext;
                            r_hi    <= r_signR ? -w_remNext : w_remNext;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_done    <= 1'b0;
                    r_div0    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_bypass  <= 1'b0;
                    r_zeroDiv <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_div0  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.div0 = r_div0;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    div_if #(.WIDTH(32)) dv ();
    div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(dv));

    int nChecks = 0;
    int nFail   = 0;
    logic [31:0] refHi = '0;
    logic [31:0] refLo = '0;

`ifdef DIV_FAST_ZERO_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    // Truncating signed division in 64-bit arithmetic; returns {rem, quo}.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int expLat(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (a == 32'd0 && FAST) return 1;
        return 32;
    endfunction

    // Called one step after a rising edge with the DUT idle.
    task automatic runDiv(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busyCnt,
                          output logic [31:0] oHi, output logic [31:0] oLo,
                          output logic oDiv0, output logic afterDone, output logic afterBusy);
        dv.start = 1'b1; dv.dividend = a; dv.divisor = b;
        @(posedge clk); #1;
        dv.start = 1'b0; dv.dividend = $urandom; dv.divisor = $urandom;
        lat = 0;
        busyCnt = (dv.busy === 1'b1) ? 1 : 0;
        while (dv.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (dv.busy === 1'b1) busyCnt++;
        end
        oHi = dv.hi; oLo = dv.lo; oDiv0 = dv.div0;
        @(posedge clk); #1;
        afterDone = dv.done; afterBusy = dv.busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; dv.start = 1'b0; dv.dividend = '0; dv.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        nChecks++; if (dv.busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b expected 0", dv.busy); end
        nChecks++; if (dv.done !== 1'b0) begin nFail++; $display("FAIL reset_done: got %b expected 0", dv.done); end
        nChecks++; if (dv.div0 !== 1'b0) begin nFail++; $display("FAIL reset_div0: got %b expected 0", dv.div0); end
        nChecks++; if (dv.hi !== 32'd0) begin nFail++; $display("FAIL reset_hi: got %h expected 0", dv.hi); end
        nChecks++; if (dv.lo !== 32'd0) begin nFail++; $display("FAIL reset_lo: got %h expected 0", dv.lo); end
        reset = 1'b0;
        refHi = '0; refLo = '0;
    endtask

    task automatic test_signs();
        logic [31:0] ta [4] = '{32'd100, -32'd100, 32'd100, -32'd100};
        logic [31:0] tb [4] = '{32'd7, 32'd7, -32'd7, -32'd7};
        logic [31:0] eLo[4] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
        logic [31:0] eHi[4] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE};
        int lat, bc; logic [31:0] h, l; logic d0, ad, ab;
        for (int i = 0; i < 4; i++) begin
            runDiv(ta[i], tb[i], lat, bc, h, l, d0, ad, ab);
            nChecks++; if (l !== eLo[i]) begin nFail++; $display("FAIL signs_lo[%0d]: got %h expected %h", i, l, eLo[i]); end
            nChecks++; if (h !== eHi[i]) begin nFail++; $display("FAIL signs_hi[%0d]: got %h expected %h", i, h, eHi[i]); end
            nChecks++; if (d0 !== 1'b0) begin nFail++; $display("FAIL signs_div0[%0d]: got %b expected 0", i, d0); end
            nChecks++; if (lat != 32) begin nFail++; $display("FAIL signs_latency[%0d]: got %0d expected 32", i, lat); end
            if (i == 0) begin
                nChecks++; if (bc != 33) begin nFail++; $display("FAIL busy_cycles: got %0d expected 33", bc); end
                nChecks++; if (ad !== 1'b0) begin nFail++; $display("FAIL done_pulse: got %b expected 0", ad); end
                nChecks++; if (ab !== 1'b0) begin nFail++; $display("FAIL busy_after: got %b expected 0", ab); end
            end
            refHi = eHi[i]; refLo = eLo[i];
        end
    endtask

    task automatic test_div0();
        int lat, bc; logic [31:0] h, l; logic d0, ad, ab;
        runDiv(32'd100, 32'd7, lat, bc, h, l, d0, ad, ab);
        runDiv(32'd55, 32'd0, lat, bc, h, l, d0, ad, ab);
        nChecks++; if (lat != 1) begin nFail++; $display("FAIL div0_latency: got %0d expected 1", lat); end
        nChecks++; if (d0 !== 1'b1) begin nFail++; $display("FAIL div0_flag: got %b expected 1", d0); end
        nChecks++; if (h !== 32'd2) begin nFail++; $display("FAIL div0_hi_hold: got %h expected 2", h); end
        nChecks++; if (l !== 32'd14) begin nFail++; $display("FAIL div0_lo_hold: got %h expected 14", l); end
        nChecks++; if (ad !== 1'b0) begin nFail++; $display("FAIL div0_done_pulse: got %b expected 0", ad); end
        runDiv(32'd9, 32'd3, lat, bc, h, l, d0, ad, ab);
        nChecks++; if (d0 !== 1'b0) begin nFail++; $display("FAIL after_div0_flag: got %b expected 0", d0); end
        nChecks++; if (l !== 32'd3) begin nFail++; $display("FAIL after_div0_lo: got %h expected 3", l); end
        nChecks++; if (h !== 32'd0) begin nFail++; $display("FAIL after_div0_hi: got %h expected 0", h); end
        refHi = 32'd0; refLo = 32'd3;
    endtask

    task automatic test_overflow();
        int lat, bc; logic [31:0] h, l; logic d0, ad, ab;
        runDiv(32'h80000000, 32'hFFFFFFFF, lat, bc, h, l, d0, ad, ab);
        nChecks++; if (l !== 32'h80000000) begin nFail++; $display("FAIL ovf_lo: got %h expected 80000000", l); end
        nChecks++; if (h !== 32'd0) begin nFail++; $display("FAIL ovf_hi: got %h expected 0", h); end
        runDiv(32'h80000000, 32'd1, lat, bc, h, l, d0, ad, ab);
        nChecks++; if (l !== 32'h80000000) begin nFail++; $display("FAIL minneg_lo: got %h expected 80000000", l); end
        nChecks++; if (h !== 32'd0) begin nFail++; $display("FAIL minneg_hi: got %h expected 0", h); end
        refHi = 32'd0; refLo = 32'h80000000;
    endtask

    task automatic test_ignore_start();
        int lat; int idle;
        dv.start = 1'b1; dv.dividend = 32'd100; dv.divisor = 32'd7;
        @(posedge clk); #1;
        dv.start = 1'b0;
        lat = 0;
        while (dv.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 10) begin dv.start = 1'b1; dv.dividend = 32'd50; dv.divisor = 32'd5; end
            if (lat == 11) dv.start = 1'b0;
        end
        nChecks++; if (lat != 32) begin nFail++; $display("FAIL ignore_latency: got %0d expected 32", lat); end
        nChecks++; if (dv.lo !== 32'd14 || dv.hi !== 32'd2) begin nFail++; $display("FAIL ignore_result: got lo=%h hi=%h expected lo=e hi=2", dv.lo, dv.hi); end
        idle = 0;
        repeat (4) begin @(posedge clk); #1; if (dv.busy === 1'b0) idle++; end
        nChecks++; if (idle != 4) begin nFail++; $display("FAIL ignore_not_queued: idle samples %0d expected 4", idle); end
        refHi = 32'd2; refLo = 32'd14;
    endtask

    task automatic test_reset_mid();
        int lat, bc; logic [31:0] h, l; logic d0, ad, ab;
        dv.start = 1'b1; dv.dividend = 32'd1000; dv.divisor = 32'd3;
        @(posedge clk); #1;
        dv.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        nChecks++; if (dv.busy !== 1'b0 || dv.done !== 1'b0) begin nFail++; $display("FAIL midreset_ctrl: got busy=%b done=%b expected 0 0", dv.busy, dv.done); end
        nChecks++; if (dv.hi !== 32'd0 || dv.lo !== 32'd0) begin nFail++; $display("FAIL midreset_result: got hi=%h lo=%h expected 0 0", dv.hi, dv.lo); end
        runDiv(32'd20, 32'd6, lat, bc, h, l, d0, ad, ab);
        nChecks++; if (l !== 32'd3 || h !== 32'd2) begin nFail++; $display("FAIL midreset_next: got lo=%h hi=%h expected 3 2", l, h); end
        refHi = 32'd2; refLo = 32'd3;
    endtask

    task automatic test_zero_dividend();
        int lat, bc; logic [31:0] h, l; logic d0, ad, ab;
        runDiv(32'd0, 32'd5, lat, bc, h, l, d0, ad, ab);
        nChecks++; if (h !== 32'd0 || l !== 32'd0 || d0 !== 1'b0) begin nFail++; $display("FAIL zero_result: got hi=%h lo=%h div0=%b expected 0 0 0", h, l, d0); end
        nChecks++; if (lat != expLat(32'd0, 32'd5)) begin nFail++; $display("FAIL zero_latency: got %0d expected %0d", lat, expLat(32'd0, 32'd5)); end
        runDiv(32'd0, 32'd0, lat, bc, h, l, d0, ad, ab);
        nChecks++; if (d0 !== 1'b1 || lat != 1) begin nFail++; $display("FAIL zero_by_zero: got div0=%b lat=%0d expected 1 1", d0, lat); end
        refHi = 32'd0; refLo = 32'd0;
    endtask

    task automatic test_back_to_back();
        int lat, lat2;
        dv.start = 1'b1; dv.dividend = 32'd12; dv.divisor = 32'd5;
        @(posedge clk); #1;
        lat = 0;
        while (dv.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        nChecks++; if (lat != 32 || dv.lo !== 32'd2 || dv.hi !== 32'd2) begin nFail++; $display("FAIL b2b_first: got lat=%0d lo=%h hi=%h expected 32 2 2", lat, dv.lo, dv.hi); end
        dv.dividend = 32'd30; dv.divisor = 32'd4;
        lat2 = 0;
        do begin @(posedge clk); #1; lat2++; end while (dv.done !== 1'b1 && lat2 < 100);
        nChecks++; if (lat2 != 34 || dv.lo !== 32'd7 || dv.hi !== 32'd2) begin nFail++; $display("FAIL b2b_second: got lat=%0d lo=%h hi=%h expected 34 7 2", lat2, dv.lo, dv.hi); end
        dv.start = 1'b0;
        @(posedge clk); #1;
        refHi = 32'd2; refLo = 32'd7;
    endtask

    task automatic test_random();
        int lat, bc; logic [31:0] h, l, a, b; logic d0, ad, ab;
        logic [63:0] m;
        for (int i = 0; i < 60; i++) begin
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'd0;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(0, 20)) - 32'd10;
                4: b = 32'hFFFFFFFF;
                default: ;
            endcase
            runDiv(a, b, lat, bc, h, l, d0, ad, ab);
            if (b != 32'd0) begin
                m = refDiv(a, b);
                refHi = m[63:32]; refLo = m[31:0];
            end
            nChecks++;
            if (h !== refHi || l !== refLo || d0 !== (b == 32'd0) || lat != expLat(a, b)) begin
                nFail++;
                $display("FAIL random[%0d] %h/%h: got hi=%h lo=%h div0=%b lat=%0d expected hi=%h lo=%h div0=%b lat=%0d",
                         i, a, b, h, l, d0, lat, refHi, refLo, (b == 32'd0), expLat(a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_signs();
        test_div0();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_zero_dividend();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
